// File: rtl/pong_pkg.sv
// Shared constants, paddle FSM state type and the auto-tracking target helper
// for the pong paddle logic.
package pong_pkg;

  localparam int sWidth  = 800;
  localparam int sHeight = 600;
  localparam int pWidth  = 50;
  localparam int pHeight = 150;
  localparam int CoordW  = 11;

  typedef enum logic [1:0] {
    IDLE,
    MOVE_UP,
    MOVE_DOWN
  } paddle_state_t;

  // Centre the paddle on the ball, limited to the legal range of top rows.
  function automatic logic [CoordW-1:0] track_target(
    input logic [CoordW-1:0] ball_y,
    input logic [CoordW-1:0] half_h,
    input logic [CoordW-1:0] top_max
  );
    logic [CoordW-1:0] t;
    if (ball_y < half_h) t = '0;
    else                 t = ball_y - half_h;
    if (t > top_max) t = top_max;
    return t;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioning: 2-flop synchronizer followed by a debouncer whose
// output only follows the synchronized input after DebounceCycles stable cycles.
module btn_debounce #(
  parameter int DebounceCycles = 1000
) (
  input  logic PixelClock,
  input  logic ResetN,
  input  logic raw,
  output logic clean
);

  localparam int CntW = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

  logic            sync_p0;
  logic            sync_p1;
  logic [CntW-1:0] cnt;

  // Stage p0/p1: metastability guard on the asynchronous button
  always_ff @(posedge PixelClock or negedge ResetN) begin
    if (!ResetN) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: any agreement with the current output restarts the count
  always_ff @(posedge PixelClock or negedge ResetN) begin
    if (!ResetN) begin
      cnt   <= '0;
      clean <= 1'b0;
    end else if (sync_p1 == clean) begin
      cnt <= '0;
    end else if (cnt == CntLast) begin
      cnt   <= '0;
      clean <= sync_p1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/paddle_ctrl.sv
// Player paddle: debounced up/down buttons drive a 3-state FSM that steps PosY
// one pixel every StepDiv cycles. Optional ball tracking under PADDLE_AI_EN.
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int pLeft          = 30,
  parameter int pTopInit       = 225,
  parameter int pWidth         = pong_pkg::pWidth,
  parameter int pHeight        = pong_pkg::pHeight,
  parameter int sHeight        = pong_pkg::sHeight,
  parameter int StepDiv        = 100000,
  parameter int DebounceCycles = 1000
) (
  input  logic        PixelClock,
  input  logic        ResetN,
  input  logic        BtnUp,
  input  logic        BtnDown,
  input  logic        AiMode,
  input  logic [10:0] BallY,
  input  logic [10:0] xPos,
  input  logic [9:0]  yPos,
  output logic [10:0] PosX,
  output logic [10:0] PosY,
  output logic        drawPaddle
);

  localparam logic [10:0] TopMax  = 11'(sHeight - pHeight);
  localparam logic [10:0] TopInit = 11'(pTopInit);
  localparam logic [10:0] Left    = 11'(pLeft);
  localparam logic [10:0] WidthW  = 11'(pWidth);
  localparam logic [10:0] HeightW = 11'(pHeight);
  localparam int          StepW   = (StepDiv > 1) ? $clog2(StepDiv) : 1;
  localparam logic [StepW-1:0] StepLast = StepW'(StepDiv - 1);

  logic              up_db;
  logic              down_db;
  logic              up_req;
  logic              down_req;
  paddle_state_t     state;
  paddle_state_t     state_nxt;
  logic [StepW-1:0]  step_cnt;
  logic [StepW-1:0]  step_cnt_nxt;
  logic              step_due;
  logic [10:0]       pos_y;
  logic [10:0]       pos_y_nxt;

  btn_debounce #(.DebounceCycles(DebounceCycles)) u_db_up (
    .PixelClock (PixelClock),
    .ResetN     (ResetN),
    .raw        (BtnUp),
    .clean      (up_db)
  );

  btn_debounce #(.DebounceCycles(DebounceCycles)) u_db_down (
    .PixelClock (PixelClock),
    .ResetN     (ResetN),
    .raw        (BtnDown),
    .clean      (down_db)
  );

`ifdef PADDLE_AI_EN
  localparam logic [10:0] HalfH = 11'(pHeight / 2);
  logic [10:0] ai_target;

  // In tracking mode the comparison against the target stands in for the buttons
  assign ai_target = track_target(BallY, HalfH, TopMax);
  assign up_req    = AiMode ? (pos_y > ai_target) : up_db;
  assign down_req  = AiMode ? (pos_y < ai_target) : down_db;
`else
  logic unused_ai;

  assign unused_ai = ^{AiMode, BallY};
  assign up_req    = up_db;
  assign down_req  = down_db;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (up_req && !down_req)      state_nxt = MOVE_UP;
        else if (down_req && !up_req) state_nxt = MOVE_DOWN;
      end
      MOVE_UP:   if (!up_req || down_req) state_nxt = IDLE;
      MOVE_DOWN: if (!down_req || up_req) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Step counter restarts on every state change, so the first move lands
  // StepDiv cycles after entering a MOVE state.
  always_comb begin
    step_due     = (state != IDLE) && (step_cnt == StepLast);
    step_cnt_nxt = '0;
    if ((state_nxt == state) && (state != IDLE) && !step_due)
      step_cnt_nxt = step_cnt + 1'b1;

    pos_y_nxt = pos_y;
    if (step_due) begin
      if ((state == MOVE_UP) && (pos_y != '0))
        pos_y_nxt = pos_y - 1'b1;
      else if ((state == MOVE_DOWN) && (pos_y < TopMax))
        pos_y_nxt = pos_y + 1'b1;
    end
  end

  always_ff @(posedge PixelClock or negedge ResetN) begin
    if (!ResetN) begin
      state    <= IDLE;
      step_cnt <= '0;
      pos_y    <= TopInit;
    end else begin
      state    <= state_nxt;
      step_cnt <= step_cnt_nxt;
      pos_y    <= pos_y_nxt;
    end
  end

  assign PosX = Left;
  assign PosY = pos_y;

  // Strict bounds: the outline rows/columns themselves are not drawn
  always_comb begin
    drawPaddle = (xPos > PosX) && (xPos < (PosX + WidthW)) &&
                 ({1'b0, yPos} > PosY) && ({1'b0, yPos} < (PosY + HeightW));
  end

endmodule

// File: tb/tb_paddle_ctrl.sv
// Self-checking bench for paddle_ctrl with a behavioural paddle model; covers
// the tracking mode when PADDLE_AI_EN is defined.
module tb_paddle_ctrl;

  localparam int STEP     = 4;
  localparam int DEB      = 3;
  localparam int TOP_INIT = 225;
  localparam int LEFT     = 30;
  localparam int PW       = 50;
  localparam int PH       = 150;
  localparam int SH       = 600;
  localparam int TOP_MAX  = SH - PH;

  logic        PixelClock = 1'b0;
  logic        ResetN     = 1'b0;
  logic        BtnUp      = 1'b0;
  logic        BtnDown    = 1'b0;
  logic        AiMode     = 1'b0;
  logic [10:0] BallY      = '0;
  logic [10:0] xPos       = '0;
  logic [9:0]  yPos       = '0;
  logic [10:0] PosX;
  logic [10:0] PosY;
  logic        drawPaddle;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: button pipelines, motion direction (-1/0/+1),
  // cycles since the current direction began, and the paddle top row.
  int m_up_s1, m_up_s2, m_up_db, m_up_run;
  int m_dn_s1, m_dn_s2, m_dn_db, m_dn_run;
  int m_dir, m_since, m_pos;

  paddle_ctrl #(
    .pLeft          (LEFT),
    .pTopInit       (TOP_INIT),
    .pWidth         (PW),
    .pHeight        (PH),
    .sHeight        (SH),
    .StepDiv        (STEP),
    .DebounceCycles (DEB)
  ) dut (
    .PixelClock (PixelClock),
    .ResetN     (ResetN),
    .BtnUp      (BtnUp),
    .BtnDown    (BtnDown),
    .AiMode     (AiMode),
    .BallY      (BallY),
    .xPos       (xPos),
    .yPos       (yPos),
    .PosX       (PosX),
    .PosY       (PosY),
    .drawPaddle (drawPaddle)
  );

  always #5 PixelClock = ~PixelClock;

  function automatic logic draw_ref(input int x, input int y, input int top);
    return (x > LEFT) && (x < LEFT + PW) && (y > top) && (y < top + PH);
  endfunction

  task automatic model_reset();
    m_up_s1 = 0; m_up_s2 = 0; m_up_db = 0; m_up_run = 0;
    m_dn_s1 = 0; m_dn_s2 = 0; m_dn_db = 0; m_dn_run = 0;
    m_dir = 0; m_since = 0; m_pos = TOP_INIT;
  endtask

  task automatic deb_model(input int raw, inout int s1, inout int s2, inout int db, inout int run);
    if (s2 != db) begin
      run++;
      if (run == DEB) begin
        db  = s2;
        run = 0;
      end
    end else begin
      run = 0;
    end
    s2 = s1;
    s1 = raw;
  endtask

  task automatic model_edge();
    int want_up, want_dn, nxt_dir, nxt_pos, nxt_since;
    if (!ResetN) begin
      model_reset();
      return;
    end
    want_up = m_up_db;
    want_dn = m_dn_db;
`ifdef PADDLE_AI_EN
    if (AiMode) begin
      int tgt;
      tgt = int'(BallY) - PH / 2;
      if (tgt < 0) tgt = 0;
      if (tgt > TOP_MAX) tgt = TOP_MAX;
      want_up = (m_pos > tgt);
      want_dn = (m_pos < tgt);
    end
`endif
    nxt_pos   = m_pos;
    nxt_since = m_since + 1;
    if ((m_dir != 0) && (nxt_since % STEP == 0)) begin
      nxt_pos = m_pos + m_dir;
      if (nxt_pos < 0) nxt_pos = 0;
      if (nxt_pos > TOP_MAX) nxt_pos = TOP_MAX;
    end
    nxt_dir = m_dir;
    if (m_dir == 0) begin
      if (want_up && !want_dn)      nxt_dir = -1;
      else if (want_dn && !want_up) nxt_dir = 1;
    end else if (m_dir < 0) begin
      if (!want_up || want_dn) nxt_dir = 0;
    end else begin
      if (!want_dn || want_up) nxt_dir = 0;
    end
    if (nxt_dir != m_dir) nxt_since = 0;
    deb_model(int'(BtnUp), m_up_s1, m_up_s2, m_up_db, m_up_run);
    deb_model(int'(BtnDown), m_dn_s1, m_dn_s2, m_dn_db, m_dn_run);
    m_dir   = nxt_dir;
    m_pos   = nxt_pos;
    m_since = nxt_since;
  endtask

  // Advance one clock: model follows the rising edge, bench resumes at the falling edge
  task automatic cycle();
    @(posedge PixelClock);
    model_edge();
    @(negedge PixelClock);
  endtask

  task automatic do_reset();
    ResetN  = 1'b0;
    BtnUp   = 1'b0;
    BtnDown = 1'b0;
    model_reset();
    cycle();
    cycle();
    ResetN = 1'b1;
  endtask

  task automatic test_reset();
    int xs[5] = '{79, 80, 50, 50, 50};
    int ys[5] = '{300, 300, 225, 374, 375};
    logic exp_d;
    ResetN = 1'b0;
    model_reset();
    repeat (3) cycle();
    n_checks++;
    if (PosY !== 11'(TOP_INIT)) $display("FAIL reset_posy got %0d expected %0d", PosY, TOP_INIT);
    else n_pass++;
    n_checks++;
    if (PosX !== 11'(LEFT)) $display("FAIL reset_posx got %0d expected %0d", PosX, LEFT);
    else n_pass++;
    xPos = 11'd31; yPos = 10'd226; #1;
    n_checks++;
    if (drawPaddle !== 1'b1) $display("FAIL draw_inside got %b expected 1", drawPaddle);
    else n_pass++;
    xPos = 11'd30; #1;
    n_checks++;
    if (drawPaddle !== 1'b0) $display("FAIL draw_left_edge got %b expected 0", drawPaddle);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      xPos = 11'(xs[i]); yPos = 10'(ys[i]); #1;
      exp_d = draw_ref(xs[i], ys[i], m_pos);
      n_checks++;
      if (drawPaddle !== exp_d)
        $display("FAIL draw_bound x=%0d y=%0d got %b expected %b", xs[i], ys[i], drawPaddle, exp_d);
      else n_pass++;
    end
    @(negedge PixelClock);
    ResetN = 1'b1;
  endtask

  task automatic test_pulse();
    do_reset();
    BtnUp = 1'b1;
    cycle();
    cycle();
    BtnUp = 1'b0;
    repeat (20) begin
      cycle();
      n_checks++;
      if (PosY !== 11'(m_pos)) $display("FAIL pulse_model got %0d expected %0d", PosY, m_pos);
      else n_pass++;
    end
    n_checks++;
    if (PosY !== 11'(TOP_INIT)) $display("FAIL pulse_hold got %0d expected %0d", PosY, TOP_INIT);
    else n_pass++;
  endtask

  task automatic test_up_held();
    int exp_y;
    do_reset();
    BtnUp = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      cycle();
      exp_y = (i < 6) ? TOP_INIT : TOP_INIT - (i - 6) / STEP;
      n_checks++;
      if (PosY !== 11'(exp_y)) $display("FAIL up_timeline cyc=%0d got %0d expected %0d", i, PosY, exp_y);
      else n_pass++;
      n_checks++;
      if (PosY !== 11'(m_pos)) $display("FAIL up_model cyc=%0d got %0d expected %0d", i, PosY, m_pos);
      else n_pass++;
    end
    BtnUp = 1'b0;
  endtask

  task automatic test_down_saturate();
    do_reset();
    BtnDown = 1'b1;
    repeat (2000) begin
      cycle();
      n_checks++;
      if (PosY > 11'(TOP_MAX)) $display("FAIL down_overrun got %0d expected <= %0d", PosY, TOP_MAX);
      else n_pass++;
      n_checks++;
      if (PosY !== 11'(m_pos)) $display("FAIL down_model got %0d expected %0d", PosY, m_pos);
      else n_pass++;
    end
    n_checks++;
    if (PosY !== 11'(TOP_MAX)) $display("FAIL down_saturate got %0d expected %0d", PosY, TOP_MAX);
    else n_pass++;
    BtnDown = 1'b0;
  endtask

  task automatic test_both();
    logic [10:0] held;
    do_reset();
    BtnDown = 1'b1;
    repeat (20) cycle();
    BtnUp = 1'b1;
    repeat (12) begin
      cycle();
      n_checks++;
      if (PosY !== 11'(m_pos)) $display("FAIL both_settle got %0d expected %0d", PosY, m_pos);
      else n_pass++;
    end
    held = PosY;
    n_checks++;
    if (held <= 11'(TOP_INIT)) $display("FAIL both_moved got %0d expected > %0d", held, TOP_INIT);
    else n_pass++;
    repeat (30) begin
      cycle();
      n_checks++;
      if (PosY !== 11'(m_pos)) $display("FAIL both_model got %0d expected %0d", PosY, m_pos);
      else n_pass++;
    end
    n_checks++;
    if (PosY !== held) $display("FAIL both_hold got %0d expected %0d", PosY, held);
    else n_pass++;
    BtnUp   = 1'b0;
    BtnDown = 1'b0;
  endtask

  task automatic test_reset_mid();
    int exp_y;
    do_reset();
    BtnDown = 1'b1;
    repeat (30) cycle();
    n_checks++;
    if (PosY <= 11'(TOP_INIT)) $display("FAIL mid_moving got %0d expected > %0d", PosY, TOP_INIT);
    else n_pass++;
    #2;
    ResetN = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (PosY !== 11'(TOP_INIT)) $display("FAIL mid_async_reset got %0d expected %0d", PosY, TOP_INIT);
    else n_pass++;
    repeat (3) cycle();
    ResetN = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      exp_y = (i < 10) ? TOP_INIT : TOP_INIT + (i - 6) / STEP;
      n_checks++;
      if (PosY !== 11'(exp_y)) $display("FAIL held_thru_reset cyc=%0d got %0d expected %0d", i, PosY, exp_y);
      else n_pass++;
    end
    BtnDown = 1'b0;
  endtask

  task automatic test_random();
    int hold;
    logic exp_d;
    do_reset();
    hold = 0;
    repeat (3000) begin
      if (hold == 0) begin
        BtnUp   = 1'($urandom_range(0, 1));
        BtnDown = 1'($urandom_range(0, 1));
        hold    = int'($urandom_range(1, 14));
      end
      hold--;
      cycle();
      n_checks++;
      if (PosY !== 11'(m_pos)) $display("FAIL rand_posy got %0d expected %0d", PosY, m_pos);
      else n_pass++;
      xPos = 11'($urandom_range(20, 90));
      yPos = 10'($urandom_range(0, 599));
      #1;
      exp_d = draw_ref(int'(xPos), int'(yPos), m_pos);
      n_checks++;
      if (drawPaddle !== exp_d)
        $display("FAIL rand_draw x=%0d y=%0d got %b expected %b", xPos, yPos, drawPaddle, exp_d);
      else n_pass++;
    end
    BtnUp   = 1'b0;
    BtnDown = 1'b0;
  endtask

  task automatic test_ai();
`ifdef PADDLE_AI_EN
    do_reset();
    AiMode = 1'b1;
    BallY  = 11'd500;
    repeat (1000) begin
      BtnUp   = 1'($urandom_range(0, 1));
      BtnDown = 1'($urandom_range(0, 1));
      cycle();
      n_checks++;
      if (PosY !== 11'(m_pos)) $display("FAIL ai_down_model got %0d expected %0d", PosY, m_pos);
      else n_pass++;
    end
    n_checks++;
    if (PosY !== 11'd425) $display("FAIL ai_low_target got %0d expected 425", PosY);
    else n_pass++;
    repeat (50) cycle();
    n_checks++;
    if (PosY !== 11'd425) $display("FAIL ai_low_hold got %0d expected 425", PosY);
    else n_pass++;
    BallY = 11'd10;
    repeat (2000) begin
      BtnUp   = 1'($urandom_range(0, 1));
      BtnDown = 1'($urandom_range(0, 1));
      cycle();
      n_checks++;
      if (PosY !== 11'(m_pos)) $display("FAIL ai_up_model got %0d expected %0d", PosY, m_pos);
      else n_pass++;
    end
    n_checks++;
    if (PosY !== 11'd0) $display("FAIL ai_top_target got %0d expected 0", PosY);
    else n_pass++;
    repeat (50) cycle();
    n_checks++;
    if (PosY !== 11'd0) $display("FAIL ai_top_hold got %0d expected 0", PosY);
    else n_pass++;
`else
    do_reset();
    AiMode = 1'b1;
    BallY  = 11'd500;
    repeat (100) begin
      cycle();
      n_checks++;
      if (PosY !== 11'(TOP_INIT)) $display("FAIL ai_ignored got %0d expected %0d", PosY, TOP_INIT);
      else n_pass++;
    end
`endif
    AiMode  = 1'b0;
    BtnUp   = 1'b0;
    BtnDown = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_pulse();
    test_up_held();
    test_down_saturate();
    test_both();
    test_reset_mid();
    test_random();
    test_ai();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
